// File: rtl/hs32_lsu.sv
// hs32_lsu -- load/store unit bridging a simple op interface to a
// request/ready memory port, with burst support, lane steering and
// load extension.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   req / rdy           op handshake: req is sampled only while rdy=1 (IDLE)
//   op_wr, op_size,     operation descriptor, latched when req is accepted
//   op_sext, op_addr,
//   op_cnt
//   wd / wd_ack         store data for the current beat; wd_ack pulses in the
//                       memory handshake cycle, after which the next beat's
//                       data must be presented
//   rd_data / rd_valid  load result, one registered pulse per beat
//   done / fault        one-cycle completion pulses; fcode holds the fault cause
//   addr, dtwm, bsel,   registered memory request fields
//   rw_mem, reqm
//   dtrm, rdym          memory read data and ready
//   dbg_state           current FSM state
//
// Memory handshake: a beat transfers in the cycle where reqm && rdym are both
// high. reqm stays high until that cycle (or a timeout) and drops on the next.
module hs32_lsu #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int MAXB = 8,
    parameter int TMO  = 255,
    localparam int NB  = DW / 8,
    localparam int CW  = $clog2(MAXB + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          rdy,
    input  logic          op_wr,
    input  logic [1:0]    op_size,
    input  logic          op_sext,
    input  logic [AW-1:0] op_addr,
    input  logic [CW-1:0] op_cnt,
    input  logic [DW-1:0] wd,
    output logic          wd_ack,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          done,
    output logic          fault,
    output logic [1:0]    fcode,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] dtwm,
    input  logic [DW-1:0] dtrm,
    output logic          reqm,
    input  logic          rdym,
    output logic          rw_mem,
    output logic [NB-1:0] bsel,
    output logic [2:0]    dbg_state
);

    localparam int LW = $clog2(NB);
    localparam int TW = $clog2(TMO + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CHK  = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_FLT  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          wr_q, wr_d;
    logic [1:0]    size_q, size_d;
    logic          sext_q, sext_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;   // address of the next beat to issue
    logic [CW-1:0] beat_q, beat_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dtwm_q, dtwm_d;
    logic [NB-1:0] bsel_q, bsel_d;
    logic          rw_q, rw_d;
    logic          reqm_q, reqm_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic [1:0]    fcode_q, fcode_d;

    logic [DW-1:0] ld_shift;
    logic [DW-1:0] ld_mask;
    logic          ld_sign;
    logic [DW-1:0] ld_data;
    logic          size_bad;
    logic          misal;
    logic          last_beat;

    function automatic logic [NB-1:0] beat_bsel(input logic [LW-1:0] lane,
                                                input logic [1:0] sz);
        logic [NB-1:0] r;
        case (sz)
            2'd0:    r = NB'(1) << lane;
            2'd1:    r = NB'(3) << lane;
            default: r = '1;
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] beat_dtwm(input logic [DW-1:0] d,
                                                input logic [LW-1:0] lane,
                                                input logic w);
        return w ? (d << {lane, 3'b000}) : '0;
    endfunction

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        size_d     = size_q;
        sext_d     = sext_q;
        cnt_d      = cnt_q;
        cur_addr_d = cur_addr_q;
        beat_d     = beat_q;
        tmo_d      = tmo_q;
        addr_d     = addr_q;
        dtwm_d     = dtwm_q;
        bsel_d     = bsel_q;
        rw_d       = rw_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        fcode_d    = fcode_q;
        // done/fault are registered from the terminal state, so they appear
        // the cycle after DONE/FLT.
        done_d     = (state_q == S_DONE);
        fault_d    = (state_q == S_FLT);

        // Load path: bring the addressed lane down to bit 0, then extend.
        ld_shift = dtrm >> {addr_q[LW-1:0], 3'b000};
        case (size_q)
            2'd0: begin
                ld_mask = DW'(8'hFF);
                ld_sign = ld_shift[7];
            end
            2'd1: begin
                ld_mask = DW'(16'hFFFF);
                ld_sign = ld_shift[15];
            end
            default: begin
                ld_mask = '1;
                ld_sign = 1'b0;
            end
        endcase
        ld_data = (ld_shift & ld_mask) | ((sext_q && ld_sign) ? ~ld_mask : '0);

        size_bad  = (size_q == 2'd3) || ((size_q == 2'd2) && (DW == 16));
        misal     = ((size_q == 2'd1) && cur_addr_q[0]) ||
                    ((size_q == 2'd2) && (cur_addr_q[1:0] != 2'b00));
        last_beat = ((beat_q + CW'(1)) == cnt_q);

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d       = op_wr;
                    size_d     = op_size;
                    sext_d     = op_sext;
                    cnt_d      = op_cnt;
                    cur_addr_d = op_addr;
                    beat_d     = '0;
                    fcode_d    = 2'd0;
                    state_d    = S_CHK;
                end
            end
            S_CHK: begin
                if (size_bad) begin
                    fcode_d = 2'd3;
                    state_d = S_FLT;
                end else if (misal) begin
                    fcode_d = 2'd1;
                    state_d = S_FLT;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = cur_addr_q;
                    bsel_d  = beat_bsel(cur_addr_q[LW-1:0], size_q);
                    dtwm_d  = beat_dtwm(wd, cur_addr_q[LW-1:0], wr_q);
                    rw_d    = wr_q;
                    tmo_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (rdym) begin
                    beat_d     = beat_q + CW'(1);
                    cur_addr_d = cur_addr_q + (AW'(1) << size_q);
                    if (!wr_q) begin
                        rd_data_d  = ld_data;
                        rd_valid_d = 1'b1;
                    end
                    state_d = last_beat ? S_DONE : S_GAP;
                end else if (tmo_q == TW'(TMO - 1)) begin
                    fcode_d = 2'd2;
                    state_d = S_FLT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_GAP: begin
                addr_d  = cur_addr_q;
                bsel_d  = beat_bsel(cur_addr_q[LW-1:0], size_q);
                dtwm_d  = beat_dtwm(wd, cur_addr_q[LW-1:0], wr_q);
                tmo_d   = '0;
                state_d = S_REQ;
            end
            S_DONE:  state_d = S_IDLE;
            S_FLT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // reqm is high exactly for the cycles spent in REQ.
        reqm_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_q       <= 1'b0;
            size_q     <= 2'd0;
            sext_q     <= 1'b0;
            cnt_q      <= '0;
            cur_addr_q <= '0;
            beat_q     <= '0;
            tmo_q      <= '0;
            addr_q     <= '0;
            dtwm_q     <= '0;
            bsel_q     <= '0;
            rw_q       <= 1'b0;
            reqm_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            fcode_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            cnt_q      <= cnt_d;
            cur_addr_q <= cur_addr_d;
            beat_q     <= beat_d;
            tmo_q      <= tmo_d;
            addr_q     <= addr_d;
            dtwm_q     <= dtwm_d;
            bsel_q     <= bsel_d;
            rw_q       <= rw_d;
            reqm_q     <= reqm_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            fcode_q    <= fcode_d;
        end
    end

    assign rdy       = (state_q == S_IDLE);
    // Store data is consumed in the handshake cycle itself.
    assign wd_ack    = (state_q == S_REQ) && rdym && wr_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign fcode     = fcode_q;
    assign addr      = addr_q;
    assign dtwm      = dtwm_q;
    assign bsel      = bsel_q;
    assign rw_mem    = rw_q;
    assign reqm      = reqm_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hs32_lsu.sv
// tb_hs32_lsu -- self-checking bench for hs32_lsu (DW=32, MAXB=8, TMO=4).
// Directed transfers plus randomized ones, all checked against a
// beat-list reference model computed from address/size arithmetic.
module tb_hs32_lsu;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 8;
    localparam int TMO  = 4;
    localparam int CW   = 4;

    logic          clk;
    logic          reset;
    logic          req;
    logic          rdy;
    logic          op_wr;
    logic [1:0]    op_size;
    logic          op_sext;
    logic [AW-1:0] op_addr;
    logic [CW-1:0] op_cnt;
    logic [DW-1:0] wd;
    logic          wd_ack;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          done;
    logic          fault;
    logic [1:0]    fcode;
    logic [AW-1:0] addr;
    logic [DW-1:0] dtwm;
    logic [DW-1:0] dtrm;
    logic          reqm;
    logic          rdym;
    logic          rw_mem;
    logic [3:0]    bsel;
    logic [2:0]    dbg_state;

    hs32_lsu #(.AW(AW), .DW(DW), .MAXB(MAXB), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .rdy(rdy),
        .op_wr(op_wr), .op_size(op_size), .op_sext(op_sext),
        .op_addr(op_addr), .op_cnt(op_cnt), .wd(wd), .wd_ack(wd_ack),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .fault(fault),
        .fcode(fcode), .addr(addr), .dtwm(dtwm), .dtrm(dtrm), .reqm(reqm),
        .rdym(rdym), .rw_mem(rw_mem), .bsel(bsel), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    bit          force_dtrm_en = 1'b0;
    logic [31:0] force_dtrm    = 32'h0;
    bit          force_wd_en   = 1'b0;
    logic [31:0] force_wd      = 32'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_fcode(input logic [1:0] sz, input logic [31:0] a);
        int nb;
        if (sz == 2'd3) return 3;
        nb = 1 << sz;
        if ((a % nb) != 0) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] ref_bsel(input logic [1:0] sz, input logic [31:0] a);
        int nb;
        int v;
        nb = 1 << sz;
        v  = ((1 << nb) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] ref_dtwm(input logic [31:0] d, input logic [31:0] a);
        logic [63:0] t;
        t = {32'h0, d} << (8 * (a % 4));
        return t[31:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic sx);
        logic [63:0] v;
        logic [63:0] lim;
        int nb;
        nb  = 1 << sz;
        v   = {32'h0, w} >> (8 * (a % 4));
        lim = 64'd1 << (8 * nb);
        v   = v % lim;
        if (sx && nb < 4 && v >= lim / 2) v = v - lim;
        return v[31:0];
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        if (sz == 2'd0) return 32'h0000_00FF;
        if (sz == 2'd1) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One transfer: issue the op, act as memory with random ready delays
    // (or never ready when hold_low), and check every beat and the ending.
    task automatic do_xfer(input logic wr, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input int cnt, input int max_wait,
                           input bit hold_low);
        logic [31:0] wd_list[$];
        logic [31:0] ba;
        logic [31:0] d;
        int fc, hs_n, rv_n, ack_n, reqm_n, wait_cnt, wait_tgt, hs_cyc, end_cyc;
        bit rv_due, drop_due, seen_done, seen_fault;

        fc = ref_fcode(sz, a);
        if (fc == 0 && hold_low && cnt > 0) fc = 2;
        for (int i = 0; i < cnt; i++)
            wd_list.push_back(force_wd_en ? force_wd : ($urandom & size_mask(sz)));
        hs_n = 0; rv_n = 0; ack_n = 0; reqm_n = 0; wait_cnt = 0; hs_cyc = 0; end_cyc = 0;
        rv_due = 0; drop_due = 0; seen_done = 0; seen_fault = 0;
        wait_tgt = $urandom_range(0, max_wait);

        @(negedge clk);
        check("rdy_idle", rdy, 1);
        op_wr   = wr;
        op_size = sz;
        op_sext = sx;
        op_addr = a;
        op_cnt  = CW'(cnt);
        wd      = (cnt > 0) ? wd_list[0] : $urandom;
        req     = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        // The latched op must not follow these.
        op_wr   = 1'($urandom);
        op_size = 2'($urandom);
        op_sext = 1'($urandom);
        op_addr = $urandom;
        op_cnt  = CW'($urandom_range(0, MAXB));

        for (int cyc = 0; cyc < 200 && !(seen_done || seen_fault); cyc++) begin
            @(negedge clk);
            if (rv_due) begin
                check("rd_valid", rd_valid, 1);
                check("rd_data", rd_data, exp_q.pop_front());
                rv_due = 0;
            end
            if (rd_valid) rv_n++;
            if (drop_due) begin
                check("reqm_drop", reqm, 0);
                drop_due = 0;
            end
            if (done)  begin seen_done  = 1; end_cyc = cyc; end
            if (fault) begin seen_fault = 1; end_cyc = cyc; end
            if (reqm) reqm_n++;
            d    = force_dtrm_en ? force_dtrm : $urandom;
            dtrm = d;
            if (reqm) rdym = !hold_low && (wait_cnt >= wait_tgt);
            else      rdym = 1'($urandom_range(0, 1));
            #1;
            if (wd_ack) ack_n++;
            if (reqm && rdym) begin
                ba = a + 32'(hs_n * (1 << sz));
                check("beat_addr", addr, ba);
                check("beat_bsel", bsel, ref_bsel(sz, ba));
                check("beat_rw", rw_mem, wr);
                if (wr) begin
                    check("beat_dtwm", dtwm, ref_dtwm(wd_list[hs_n], ba));
                    check("beat_wd_ack", wd_ack, 1);
                    if (hs_n + 1 < cnt) wd = wd_list[hs_n + 1];
                end else begin
                    exp_q.push_back(ref_load(d, ba, sz, sx));
                    rv_due = 1;
                end
                hs_n++;
                hs_cyc   = cyc;
                drop_due = 1;
                wait_cnt = 0;
                wait_tgt = $urandom_range(0, max_wait);
            end else if (reqm) begin
                wait_cnt++;
            end
        end
        rdym = 1'b0;

        check("xfer_end", seen_done || seen_fault, 1);
        check("done_flag", seen_done, fc == 0);
        check("fault_flag", seen_fault, fc != 0);
        check("fcode", fcode, fc);
        check("beats", hs_n, (fc == 0) ? cnt : 0);
        check("rd_valid_n", rv_n, (fc == 0 && !wr) ? cnt : 0);
        check("wd_ack_n", ack_n, (fc == 0 && wr) ? cnt : 0);
        if (fc == 0 && cnt > 0) check("done_lat", end_cyc - hs_cyc, 2);
        if (fc == 2) check("tmo_cycles", reqm_n, TMO);
        if (fc == 1 || fc == 3) check("no_reqm", reqm_n, 0);
        check("reqm_idle", reqm, 0);
        check("exp_q_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rq;
        int ev;
        logic [1:0]  sz;
        logic [31:0] a;

        req = 0; op_wr = 0; op_size = 0; op_sext = 0; op_addr = 0; op_cnt = 0;
        wd = 0; dtrm = 0; rdym = 0;
        do_reset();

        check("rst_rdy", rdy, 1);
        check("rst_reqm", reqm, 0);
        check("rst_addr", addr, 0);
        check("rst_bsel", bsel, 0);
        check("rst_dtwm", dtwm, 0);
        check("rst_fcode", fcode, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_rd_valid", rd_valid, 0);

        // Word load burst with memory always ready.
        do_xfer(1'b0, 2'd2, 1'b0, 32'h100, 3, 0, 0);
        check("burst_last_addr", addr, 32'h108);

        // Byte loads at lane 3, sign vs zero extension.
        force_dtrm_en = 1'b1;
        force_dtrm    = 32'h8012_3456;
        do_xfer(1'b0, 2'd0, 1'b1, 32'h203, 1, 1, 0);
        check("sext_data", rd_data, 32'hFFFF_FF80);
        check("sext_bsel", bsel, 4'b1000);
        do_xfer(1'b0, 2'd0, 1'b0, 32'h203, 1, 1, 0);
        check("zext_data", rd_data, 32'h0000_0080);
        force_dtrm_en = 1'b0;

        // Half store at upper lanes.
        force_wd_en = 1'b1;
        force_wd    = 32'h0000_BEEF;
        do_xfer(1'b1, 2'd1, 1'b0, 32'h12, 1, 1, 0);
        check("st_dtwm", dtwm, 32'hBEEF_0000);
        check("st_bsel", bsel, 4'b1100);
        check("st_rw", rw_mem, 1);
        force_wd_en = 1'b0;

        // Faults: misaligned word, reserved size, timeout.
        do_xfer(1'b0, 2'd2, 1'b0, 32'h102, 1, 0, 0);
        do_xfer(1'b0, 2'd3, 1'b0, 32'h100, 2, 0, 0);
        do_xfer(1'b0, 2'd2, 1'b0, 32'h300, 2, 0, 1);

        // Zero-beat transfer and address wrap.
        do_xfer(1'b1, 2'd2, 1'b0, 32'h400, 0, 0, 0);
        do_xfer(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFE, 3, 2, 0);
        check("wrap_addr", addr, 32'h0000_0002);

        // Randomized transfers.
        for (int t = 0; t < 40; t++) begin
            ev = $urandom_range(0, 9);
            sz = (ev < 3) ? 2'd0 : (ev < 6) ? 2'd1 : (ev < 9) ? 2'd2 : 2'd3;
            a  = $urandom;
            if ($urandom_range(0, 4) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            do_xfer(1'($urandom), sz, 1'($urandom), a, $urandom_range(0, MAXB), 2, 0);
        end

        // Reset in the middle of a store burst, during the second beat.
        @(negedge clk);
        op_wr = 1'b1; op_size = 2'd2; op_sext = 1'b0; op_addr = 32'h40; op_cnt = 4'd4;
        wd = $urandom | 32'h1;
        req = 1'b1;
        @(posedge clk);
        #1;
        req  = 1'b0;
        rdym = 1'b1;
        rq   = 0;
        for (int c = 0; c < 20 && rq < 2; c++) begin
            @(negedge clk);
            if (reqm) rq++;
        end
        check("mid_reqm", reqm, 1);
        reset = 1'b1;
        #1;
        rdym = 1'b0;
        check("mr_rdy", rdy, 1);
        check("mr_reqm", reqm, 0);
        check("mr_addr", addr, 0);
        check("mr_dtwm", dtwm, 0);
        check("mr_bsel", bsel, 0);
        check("mr_rw", rw_mem, 0);
        check("mr_rd_data", rd_data, 0);
        check("mr_rd_valid", rd_valid, 0);
        check("mr_wd_ack", wd_ack, 0);
        check("mr_done", done, 0);
        check("mr_fault", fault, 0);
        check("mr_fcode", fcode, 0);
        ev = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || fault) ev++;
        end
        check("mr_no_end", ev, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        // Accepted on the first edge after release.
        do_xfer(1'b0, 2'd2, 1'b0, 32'h500, 2, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hs32_lsu.md
HS32_LSU -- requirements
Module: hs32_lsu

Interface
REQ-001 Parameter AW, default 32: address width in bits.
REQ-002 Parameter DW, default 32, legal 16|32: data bus width; lanes NB=DW/8.
REQ-003 Parameter MAXB, default 8: maximum beats per burst; CW=$clog2(MAXB+1).
REQ-004 Parameter TMO, default 255: wait cycles allowed for rdym before bus fault.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req  in  1  start a transfer; sampled only when rdy=1.
REQ-008 rdy  out  1  high only in IDLE.
REQ-009 op_wr  in  1  1=store, 0=load.
REQ-010 op_size  in  2  0=byte, 1=half, 2=word (word illegal when DW=16); 3 reserved.
REQ-011 op_sext  in  1  sign-extend byte/half loads.
REQ-012 op_addr  in  AW  first-beat byte address.
REQ-013 op_cnt  in  CW  beat count, 0..MAXB.
REQ-014 wd  in  DW  store data for current beat, right-aligned.
REQ-015 wd_ack  out  1  one-cycle pulse: current wd consumed, present next beat.
REQ-016 rd_data  out  DW  load result, right-aligned, extended.
REQ-017 rd_valid  out  1  one-cycle pulse per loaded beat.
REQ-018 done  out  1  one-cycle pulse: transfer completed without fault.
REQ-019 fault  out  1  one-cycle pulse: transfer aborted.
REQ-020 fcode  out  2  1=misaligned, 2=timeout, 3=illegal size; held until next req.
REQ-021 addr  out  AW  memory address (registered).
REQ-022 dtwm  out  DW  memory write data (registered).
REQ-023 dtrm  in  DW  memory read data, valid when reqm&&rdym.
REQ-024 reqm  out  1  memory request.
REQ-025 rdym  in  1  memory ready/acknowledge.
REQ-026 rw_mem  out  1  1=write, 0=read.
REQ-027 bsel  out  NB  byte-lane enables, registered with addr.

Function
REQ-028 States SHALL be IDLE, CHK, REQ, GAP, DONE, FLT.
REQ-029 IDLE: on req, latch op_*, clear fcode, beat counter=0, go CHK next cycle.
REQ-030 CHK: op_size=3 or (op_size=2 and DW=16) -> FLT fcode=3; else misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> FLT fcode=1; else op_cnt=0 -> DONE; else drive addr, bsel, rw_mem, dtwm and go REQ.
REQ-031 REQ: reqm=1; handshake is the cycle reqm&&rdym; reqm SHALL drop the cycle after handshake.
REQ-032 Handshake: beat counter+1, address += 1<<op_size (wraps modulo 2^AW, no fault); last beat -> DONE, else GAP.
REQ-033 GAP: one cycle with reqm=0, next beat's addr/bsel/dtwm loaded, then REQ.
REQ-034 Lane = addr[log2(NB)-1:0]; bsel = byte 1<<lane, half 2'b11<<lane, word all ones.
REQ-035 Store: dtwm = wd shifted left by 8*lane; wd_ack pulses in handshake cycle.
REQ-036 Load: dtrm shifted right by 8*lane, masked to size, sign-extended if op_sext else zero; rd_data/rd_valid registered, valid the cycle after handshake.
REQ-037 Timeout counter resets at each REQ entry; reaching TMO cycles in REQ without handshake -> FLT fcode=2, reqm=0 next cycle.
REQ-038 DONE and FLT last one cycle, pulse done/fault respectively, return to IDLE.
REQ-039 req while rdy=0 SHALL be ignored; op_* changes after IDLE SHALL not affect the transfer.
REQ-040 rdym outside REQ SHALL be ignored.

Reset
REQ-041 reset SHALL force IDLE and zero addr, dtwm, bsel, reqm, rw_mem, rd_data, rd_valid, wd_ack, done, fault, fcode, counters, asynchronously, including mid-burst.
REQ-042 First req SHALL be accepted on the first clk edge after reset deasserts.

Verification
REQ-043 Load word, addr=0x100, cnt=3, rdym tied 1 -> addr 0x100,0x104,0x108; three rd_valid; done 2 cycles after third handshake.
REQ-044 Load byte sext, addr=0x203, dtrm=0x80xxxxxx -> bsel=4'b1000, rd_data=0xFFFFFF80; zext -> 0x00000080.
REQ-045 Store half, addr=0x12, wd=0xBEEF -> dtwm=0xBEEF0000, bsel=4'b1100, rw_mem=1, one wd_ack.
REQ-046 Load word addr=0x102 -> no reqm, fault pulse, fcode=1; op_size=3 -> fcode=3.
REQ-047 rdym held 0, TMO=4 -> fault after 4 REQ cycles, fcode=2, reqm low.
REQ-048 reset asserted mid-burst beat 2 -> all outputs zero immediately, rdy=1 after release, no done/fault.
